seq_divider: RTL and testbench

- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. Division is computed by repeated trial subtraction, one quotient bit per cycle.
- Sits beside the ALU in the EX stage. The pipeline control stalls on `busy` and consumes `result` when `done` pulses.
- Each trial subtraction is an N+1-bit add of the inverted divisor with carry-in = 1, built from the team's existing ripple-carry adder.

---
 rtl/seq_divider_if.sv | 33 +++
 rtl/seq_divider.sv | 182 ++++++++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle between the EX-stage control and the sequential
// divider.
//   start    : request pulse (driven by master)
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   dividend : rs1 value, sampled with start
//   divisor  : rs2 value, sampled with start
//   busy     : divider is computing (driven by slave)
//   done     : one-cycle pulse, result valid
//   result   : quotient or remainder, held until the next accepted start
// ---------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int N = 32
);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] result;

   modport master (
      output start, op, dividend, divisor,
      input  busy, done, result
   );

   modport slave (
      input  start, op, dividend, divisor,
      output busy, done, result
   );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
// per cycle. Division by zero and signed overflow are resolved at start and
// report after one cycle; all other operations take N+2 cycles.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : seq_divider_if.slave (start/op/dividend/divisor in,
//         busy/done/result out)
// ---------------------------------------------------------------------------
module seq_divider #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  result_q, result_d;
   logic [1:0]    op_q, op_d;
   logic          sa_q, sa_d;
   logic          sb_q, sb_d;

   // Start-time decode of the incoming operands.
   logic          is_signed;
   logic          a_neg, b_neg;
   logic [N-1:0]  a_mag, b_mag;
   logic          div_zero, sgn_ovf;

   assign is_signed = ~bus.op[0];
   assign a_neg     = is_signed & bus.dividend[N-1];
   assign b_neg     = is_signed & bus.divisor[N-1];
   // Magnitude of 100..0 wraps back to 100..0, which is correct read unsigned.
   assign a_mag     = a_neg ? -bus.dividend : bus.dividend;
   assign b_mag     = b_neg ? -bus.divisor  : bus.divisor;
   assign div_zero  = (bus.divisor == '0);
   assign sgn_ovf   = is_signed & (bus.dividend == {1'b1, {(N-1){1'b0}}})
                      & (bus.divisor == '1);

   // Trial subtraction: rem_sh + ~divisor + 1 as an N+1-bit ripple-carry add.
   // rem_sh < 2*divisor, so the N+1-bit result never overflows and its MSB
   // is the sign of the trial.
   logic [N:0] rem_sh;
   logic [N:0] sub_b;
   logic [N:0] trial;

   assign rem_sh = {rem_q, quo_q[N-1]};
   assign sub_b  = {1'b1, ~dvs_q};

   always_comb begin
      logic c;
      c     = 1'b1;
      trial = '0;
      for (int i = 0; i <= N; i++) begin
         trial[i] = rem_sh[i] ^ sub_b[i] ^ c;
         c        = (rem_sh[i] & sub_b[i]) | (c & (rem_sh[i] ^ sub_b[i]));
      end
   end

   // Sign fix-up of the unsigned core results.
   logic [N-1:0] quo_fix, rem_fix;

   assign quo_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
   assign rem_fix = sa_q ? -rem_q : rem_q;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      // NOTE: the datapath is only a handful of registers, so all of it is
      // reset; this also keeps result at zero after reset.
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      // NOTE: every signal gets a hold default first so no path infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d  = bus.op;
               sa_d  = a_neg;
               sb_d  = b_neg;
               dvs_d = b_mag;
               rem_d = '0;
               quo_d = a_mag;
               cnt_d = CW'(N - 1);
               if (div_zero) begin
                  result_d = bus.op[1] ? bus.dividend : '1;
                  state_d  = S_DONE;
               end else if (sgn_ovf) begin
                  result_d = bus.op[1] ? '0 : bus.dividend;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end

         S_CALC: begin
            quo_d = {quo_q[N-2:0], ~trial[N]};
            rem_d = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
            // cnt_q counts the steps still to go after this one.
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_FIX: begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode.
   logic busy, done;

   always_comb begin
      busy = (state_q == S_CALC) || (state_q == S_FIX);
      done = (state_q == S_DONE);
   end

   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider: each accepted request pushes its expected
// result, latency and busy length; the done monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_seq_divider;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_divider_if #(.N(N)) bus ();

   seq_divider #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [N-1:0] res;
      int           lat;
      int           bsy;
      string        tag;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int start_cyc = 0;
   int busy_cnt  = 0;
   int done_seen = 0;

   task automatic check(input string tag, input logic [N-1:0] obs,
                        input logic [N-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model of the RV32M divide semantics.
   function automatic exp_t model(input logic [1:0] op, input logic [N-1:0] a,
                                  input logic [N-1:0] b, input string tag);
      exp_t         r_e;
      logic [N-1:0] q, r;
      logic         sgn, ovf;
      sgn     = ~op[0];
      ovf     = sgn && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
      r_e.lat = N + 2;
      r_e.bsy = N + 1;
      if (b == '0) begin
         q = '1;
         r = a;
         r_e.lat = 1;
         r_e.bsy = 0;
      end else if (ovf) begin
         q = a;
         r = '0;
         r_e.lat = 1;
         r_e.bsy = 0;
      end else if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      r_e.res = op[1] ? r : q;
      r_e.tag = tag;
      return r_e;
   endfunction

   // Done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.start && !bus.busy && !bus.done) begin
            start_cyc = cyc;
            busy_cnt  = 0;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
               check("done_with_empty_queue", N'(bus.done), '0);
            end else begin
               e = sb_q.pop_front();
               check({e.tag, "_res"}, bus.result, e.res);
               check({e.tag, "_lat"}, N'(cyc - start_cyc), N'(e.lat));
               check({e.tag, "_busy"}, N'(busy_cnt), N'(e.bsy));
            end
         end
      end
   end

   // Drive one start pulse; operands are scrambled afterwards.
   task automatic issue(input logic [1:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input string tag,
                        input bit push = 1'b1);
      if (push) sb_q.push_back(model(op, a, b, tag));
      bus.op       = op;
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      bus.op       = 2'($urandom_range(0, 3));
   endtask

   // Wait for done (bounded); optionally step into the following IDLE cycle.
   task automatic wait_done(input string tag, input bit step_out = 1'b1);
      int n = 0;
      while (!bus.done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.done) begin
         check({tag, "_timeout"}, N'(bus.done), N'(1));
      end else if (step_out) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      logic [1:0]   r_op;
      logic [N-1:0] r_a, r_b;

      bus.start    = 1'b0;
      bus.op       = 2'b00;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   N'(bus.busy), '0);
      check("rst_done",   N'(bus.done), '0);
      check("rst_result", bus.result,   '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases, each started in the IDLE cycle right after DONE.
      issue(2'b01, 32'd100, 32'd7, "divu_100_7");            wait_done("divu_100_7");
      issue(2'b11, 32'd100, 32'd7, "remu_100_7");            wait_done("remu_100_7");
      issue(2'b00, -32'd7,  32'd2, "div_m7_2");              wait_done("div_m7_2");
      issue(2'b10, -32'd7,  32'd2, "rem_m7_2");              wait_done("rem_m7_2");
      issue(2'b10, 32'd7,  -32'd2, "rem_7_m2");              wait_done("rem_7_m2");
      issue(2'b00, 32'd7,  -32'd2, "div_7_m2");              wait_done("div_7_m2");
      issue(2'b01, 32'h1234, 32'd0, "divu_by0");             wait_done("divu_by0");
      issue(2'b10, 32'h1234, 32'd0, "rem_by0");              wait_done("rem_by0");
      issue(2'b00, -32'd9,   32'd0, "div_neg_by0");          wait_done("div_neg_by0");
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); wait_done("div_ovf");
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"); wait_done("rem_ovf");
      issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, "divu_big"); wait_done("divu_big");
      issue(2'b00, 32'h8000_0000, 32'd2, "div_min_2");       wait_done("div_min_2");

      // Starts while busy and while in DONE are ignored.
      d0 = done_seen;
      issue(2'b01, 32'd1000, 32'd10, "divu_busy");
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      issue(2'b00, 32'd5, 32'd1, "ignored_busy", 1'b0);
      wait_done("divu_busy", 1'b0);
      issue(2'b01, 32'd77, 32'd7, "ignored_done", 1'b0);
      issue(2'b01, 32'd50, 32'd5, "after_busy");
      wait_done("after_busy");
      check("busy_done_pulses", N'(done_seen - d0), N'(2));

      // Reset in the middle of CALC discards the operation.
      issue(2'b01, 32'hFFFF_FFFF, 32'd3, "rst_victim", 1'b0);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_busy",   N'(bus.busy), '0);
      check("midrst_done",   N'(bus.done), '0);
      check("midrst_result", bus.result,   '0);
      rst = 1'b0;
      d0  = done_seen;
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      check("midrst_no_done", N'(done_seen - d0), '0);
      issue(2'b01, 32'd9, 32'd3, "divu_9_3");
      wait_done("divu_9_3");

      // Random operations with a bias toward small and zero divisors.
      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         case ($urandom_range(0, 4))
            0:       r_b = $urandom;
            1:       r_b = N'($urandom_range(1, 15));
            2:       r_b = -N'($urandom_range(1, 15));
            3:       r_b = r_a >> $urandom_range(0, 31);
            default: r_b = '0;
         endcase
         issue(r_op, r_a, r_b, $sformatf("rnd%0d_op%0d", i, r_op));
         wait_done($sformatf("rnd%0d", i));
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", N'(sb_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
